// File: rtl/clock_sched_pkg.sv
// Shared types and constants for the clock-enable scheduler.
package clock_sched_pkg;

    localparam int unsigned DIV_W_DEFAULT = 16;

    typedef logic [DIV_W_DEFAULT-1:0] div_t;

    // Per-channel configuration, used for both shadow (pending) and applied state.
    typedef struct packed {
        div_t div;
        logic enable;
    } chan_cfg_t;

    // Channel-select width, never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CH_W_DEFAULT = ch_width(4);

endpackage

// File: rtl/clock_sched_channel.sv
// One tick channel: counter, applied/shadow configuration, tick and square wave.
// Optional CLOCK_SCHED_SYNC_EN adds a phase-align input.
module clock_sched_channel
    import clock_sched_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CLOCK_SCHED_SYNC_EN
    input  logic             sync_pulse,
`endif
    input  logic             load,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_enable,
    output logic             tick,
    output logic             sq_out,
    output logic             active,
    output logic             pending
);

    chan_cfg_t        cur;
    chan_cfg_t        shd;
    logic [DIV_W-1:0] count;
    logic             sync;
    logic             boundary;
    logic             apply;

`ifdef CLOCK_SCHED_SYNC_EN
    assign sync = sync_pulse;
`else
    assign sync = 1'b0;
`endif

    // Last cycle of the current period of an enabled channel.
    assign boundary = cur.enable && (count == DIV_W'(cur.div));

    // Pending settings land at a period boundary, immediately when idle, or on sync.
    assign apply    = pending && (sync || !cur.enable || boundary);
    assign active   = cur.enable;

    // Configuration capture/apply and the period counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur     <= '{div: div_t'(DEFAULT_DIV), enable: 1'b0};
            shd     <= '{div: div_t'(DEFAULT_DIV), enable: 1'b0};
            pending <= 1'b0;
            count   <= '0;
            tick    <= 1'b0;
            sq_out  <= 1'b0;
        end else begin
            // load is only possible while nothing is pending, so it never meets apply
            if (apply) begin
                cur     <= shd;
                pending <= 1'b0;
            end else if (load) begin
                shd     <= '{div: div_t'(cfg_div), enable: cfg_enable};
                pending <= 1'b1;
            end

            if (sync && cur.enable) begin
                count  <= '0;
                tick   <= 1'b0;
                sq_out <= 1'b0;
            end else if (boundary) begin
                count  <= '0;
                tick   <= 1'b1;
                sq_out <= ~sq_out;
            end else if (cur.enable) begin
                count  <= count + DIV_W'(1);
                tick   <= 1'b0;
            end else begin
                count  <= '0;
                tick   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_enable_scheduler.sv
// Multi-channel programmable clock-enable generator with a shared config port.
// Optional CLOCK_SCHED_SYNC_EN adds sync_pulse to phase-align all channels.
module clock_enable_scheduler
    import clock_sched_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = DIV_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef CLOCK_SCHED_SYNC_EN
    input  logic                           sync_pulse,
`endif
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [ch_width(NUM_CH)-1:0]    cfg_ch,
    input  logic [DIV_W-1:0]               cfg_div,
    input  logic                           cfg_enable,
    output logic [NUM_CH-1:0]              tick,
    output logic [NUM_CH-1:0]              sq_out,
    output logic [NUM_CH-1:0]              active,
    output logic [NUM_CH-1:0]              pending
);

    localparam int unsigned CW    = ch_width(NUM_CH);
    localparam int unsigned SLOTS = 1 << CW;

    logic [SLOTS-1:0] pend_ext;
    logic             xfer;

    // Unused select codes read as not-pending, so out-of-range requests are accepted and dropped.
    always_comb begin
        pend_ext             = '0;
        pend_ext[NUM_CH-1:0] = pending;
    end

    assign cfg_ready = ~pend_ext[cfg_ch];
    assign xfer      = cfg_valid && cfg_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_sched_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
`ifdef CLOCK_SCHED_SYNC_EN
            .sync_pulse (sync_pulse),
`endif
            .load       (xfer && (int'(cfg_ch) == i)),
            .cfg_div    (cfg_div),
            .cfg_enable (cfg_enable),
            .tick       (tick[i]),
            .sq_out     (sq_out[i]),
            .active     (active[i]),
            .pending    (pending[i])
        );
    end

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Scoreboard bench for clock_enable_scheduler; honours CLOCK_SCHED_SYNC_EN.
`timescale 1ns/1ps
module tb_clock_enable_scheduler;

    localparam int NC = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_enable = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [DW-1:0] cfg_div = '0;
    logic          cfg_ready;
    logic [NC-1:0] tick, sq_out, active, pending;
`ifdef CLOCK_SCHED_SYNC_EN
    logic          sync_pulse = 1'b0;
    bit            want_sync = 1'b0;
`endif

    clock_enable_scheduler #(
        .NUM_CH      (NC),
        .DIV_W       (DW),
        .DEFAULT_DIV (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef CLOCK_SCHED_SYNC_EN
        .sync_pulse (sync_pulse),
`endif
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_enable (cfg_enable),
        .tick       (tick),
        .sq_out     (sq_out),
        .active     (active),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NC-1:0] tick;
        logic [NC-1:0] sq;
        logic [NC-1:0] act;
        logic [NC-1:0] pend;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: each enabled channel is described by the absolute edge
    // index of its next tick; a period is div+1 edges.
    bit [NC-1:0] m_act, m_pend, m_sq, m_shen;
    int unsigned m_div[NC];
    int unsigned m_shdiv[NC];
    longint      m_next[NC];
    longint      n = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_act = '0; m_pend = '0; m_sq = '0; m_shen = '0;
        for (int c = 0; c < NC; c++) begin
            m_div[c] = 3; m_shdiv[c] = 3; m_next[c] = 0;
        end
    endfunction

    // Advance the model across edge n and queue the outputs expected after it.
    function automatic void step(input bit acc, input int unsigned ch, input int unsigned dv,
                                 input bit en, input bit sy);
        exp_t e;
        bit   t, bnd, app;
        e = '0;
        for (int c = 0; c < NC; c++) begin
            t   = 1'b0;
            bnd = m_act[c] && (m_next[c] == n);
            if (sy) begin
                if (m_act[c]) begin
                    m_sq[c]   = 1'b0;
                    m_next[c] = n + m_div[c] + 1;
                end
                app = m_pend[c];
            end else begin
                if (bnd) begin
                    t         = 1'b1;
                    m_sq[c]   = ~m_sq[c];
                    m_next[c] = n + m_div[c] + 1;
                end
                app = m_pend[c] && (!m_act[c] || bnd);
            end
            if (app) begin
                m_div[c]  = m_shdiv[c];
                m_act[c]  = m_shen[c];
                m_pend[c] = 1'b0;
                m_next[c] = n + m_div[c] + 1;
            end
            e.tick[c] = t;
        end
        if (acc) begin
            m_shdiv[ch] = dv;
            m_shen[ch]  = en;
            m_pend[ch]  = 1'b1;
        end
        e.sq   = m_sq;
        e.act  = m_act;
        e.pend = m_pend;
        q.push_back(e);
        n++;
    endfunction

    // One clock cycle of stimulus; entered and left 2 ns after a rising edge.
    task automatic cyc(input bit v, input int unsigned ch, input int unsigned dv, input bit en);
        bit sy_eff;
        bit exp_rdy;
        bit acc;
        sy_eff     = 1'b0;
        cfg_valid  = v;
        cfg_ch     = 2'(ch);
        cfg_div    = DW'(dv);
        cfg_enable = en;
`ifdef CLOCK_SCHED_SYNC_EN
        sync_pulse = want_sync;
        sy_eff     = want_sync;
        want_sync  = 1'b0;
`endif
        #1;
        exp_rdy = 1'b1;
        if (ch < NC) exp_rdy = !m_pend[ch];
        chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, exp_rdy});
        acc = v && exp_rdy && (ch < NC);
        step(acc, ch, dv, en, sy_eff);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int k);
        repeat (k) cyc(1'b0, 0, 0, 1'b0);
    endtask

    // Idle until channel c is enabled with `left` cycles to go before its next tick edge.
    task automatic wait_left(input int c, input longint left);
        int guard;
        guard = 0;
        while (!(m_act[c] && ((m_next[c] - n) == left))) begin
            if (guard == 100) begin
                checks++;
                errors++;
                $display("FAIL wait_ch%0d: got timeout expected left=%0d", c, left);
                return;
            end
            cyc(1'b0, 0, 0, 1'b0);
            guard++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tick"},    {29'b0, tick},    32'd0);
        chk({tag, "_sq"},      {29'b0, sq_out},  32'd0);
        chk({tag, "_active"},  {29'b0, active},  32'd0);
        chk({tag, "_pending"}, {29'b0, pending}, 32'd0);
        chk({tag, "_ready"},   {31'b0, cfg_ready}, 32'd1);
    endtask

    // Monitor: compare registered outputs against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("tick",    {29'b0, tick},    {29'b0, e.tick});
                chk("sq_out",  {29'b0, sq_out},  {29'b0, e.sq});
                chk("active",  {29'b0, active},  {29'b0, e.act});
                chk("pending", {29'b0, pending}, {29'b0, e.pend});
            end
        end
    end

    initial begin
        bit          v, en;
        int unsigned ch, dv;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        #1;
        rst = 1'b1;

        idle(20);

        // Enable ch0 at div=3 from idle.
        cyc(1'b1, 0, 3, 1'b1);
        idle(12);

        // ch1 at div=9, then retune to div=1 mid-period; a second ch1 request stalls, ch2 gets through.
        cyc(1'b1, 1, 9, 1'b1);
        idle(14);
        wait_left(1, 6);
        cyc(1'b1, 1, 1, 1'b1);
        cyc(1'b1, 1, 5, 1'b1);
        cyc(1'b1, 2, 7, 1'b1);
        idle(14);

        // ch0 retuned 3 -> 5 on its boundary cycle.
        wait_left(0, 0);
        cyc(1'b1, 0, 5, 1'b1);
        idle(16);

        // Disable ch2 (div=7) while its counter is 2.
        wait_left(2, 5);
        cyc(1'b1, 2, 7, 1'b0);
        idle(14);

        // Out-of-range channel is accepted and dropped; div=0 runs tick continuously.
        cyc(1'b1, 3, 0, 1'b1);
        cyc(1'b1, 2, 0, 1'b1);
        idle(6);

`ifdef CLOCK_SCHED_SYNC_EN
        cyc(1'b1, 0, 3, 1'b1);
        idle(8);
        cyc(1'b1, 1, 5, 1'b1);
        idle(9);
        wait_left(1, 3);
        cyc(1'b1, 1, 2, 1'b1);
        want_sync = 1'b1;
        cyc(1'b0, 0, 0, 1'b0);
        idle(14);
`endif

        // Asynchronous reset in the middle of activity.
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle(4);

        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 99) < 40);
            ch = $urandom_range(0, 3);
            dv = $urandom_range(0, 7);
            en = ($urandom_range(0, 3) != 0);
`ifdef CLOCK_SCHED_SYNC_EN
            want_sync = ($urandom_range(0, 49) == 0);
`endif
            cyc(v, ch, dv, en);
        end
        idle(2);

        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
